// File: rtl/apb_req_arbiter_pkg.sv
// Shared APB front-end definitions: default bus widths and the arbiter FSM encoding.
package apb_defs;

  localparam int NUM_REQ_DEF = 4;
  localparam int ADDR_W_DEF  = 9;
  localparam int DATA_W_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/apb_req_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
// Zero latency; no backpressure of its own, the caller decides when a grant is used.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    win_o,
  output logic               any_o
);

  int idx;

  always_comb begin
    gnt_o = '0;
    win_o = '0;
    any_o = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_o && req_i[idx]) begin
        any_o = 1'b1;
        win_o = idx[ID_W-1:0];
      end
    end
    gnt_o[win_o] = any_o;
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin front end sharing one APB master between NUM_REQ requesters, one command in flight.
// Accept->rsp is 4 cycles plus bus wait states; req_ready is only offered in IDLE.
module apb_req_arbiter
  import apb_defs::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                         pclk,
  input  logic                         presetn,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
  output logic                         rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic                         busy,
  output logic                         m_transfer,
  output logic                         m_read,
  output logic                         m_write,
  output logic [ADDR_W-1:0]            m_read_paddr,
  output logic [ADDR_W-1:0]            m_write_paddr,
  output logic [DATA_W-1:0]            m_write_data,
  input  logic                         penable,
  input  logic                         pready,
  input  logic                         pslverr,
  input  logic [DATA_W-1:0]            prdata
);

  localparam int ID_W = $clog2(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     win;
  logic                any_req;
  logic                drive;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt),
    .win_o   (win),
    .any_o   (any_req)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        // Gated by presetn so a requester is never told it was accepted while reset holds us.
        if (any_req && presetn) begin
          req_ready = gnt;
          id_d      = win;
          wr_d      = req_write[win];
          addr_d    = req_addr[int'(win)*ADDR_W +: ADDR_W];
          wdata_d   = req_wdata[int'(win)*DATA_W +: DATA_W];
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (penable && pready) begin
          rdata_d = wr_q ? '0 : prdata;
          err_d   = pslverr;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        ptr_d   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign drive         = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign busy          = (state_q != ST_IDLE);
  assign m_transfer    = (state_q == ST_ISSUE);
  assign m_write       = drive &  wr_q;
  assign m_read        = drive & ~wr_q;
  assign m_write_paddr = m_write ? addr_q  : '0;
  assign m_read_paddr  = m_read  ? addr_q  : '0;
  assign m_write_data  = m_write ? wdata_q : '0;

  assign rsp_valid     = (state_q == ST_RESP);
  assign rsp_id        = rsp_valid ? id_q    : '0;
  assign rsp_rdata     = rsp_valid ? rdata_q : '0;
  assign rsp_err       = rsp_valid & err_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench: requester driver, APB bus responder and a round-robin reference model.
module tb_apb_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 9;
  localparam int DW = 8;
  localparam int IW = 2;

  logic            pclk = 1'b0;
  logic            presetn = 1'b0;
  logic [N-1:0]    req_valid, req_ready, req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic            rsp_valid, rsp_err, busy;
  logic [IW-1:0]   rsp_id;
  logic [DW-1:0]   rsp_rdata;
  logic            m_transfer, m_read, m_write;
  logic [AW-1:0]   m_read_paddr, m_write_paddr;
  logic [DW-1:0]   m_write_data;
  logic            penable = 1'b0, pready = 1'b0, pslverr = 1'b0;
  logic [DW-1:0]   prdata = '0;

  apb_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .m_transfer(m_transfer), .m_read(m_read), .m_write(m_write),
    .m_read_paddr(m_read_paddr), .m_write_paddr(m_write_paddr), .m_write_data(m_write_data),
    .penable(penable), .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int            id;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            acc;
  } cmd_t;

  int   checks = 0, errors = 0;
  int   cyc = 0;
  logic rst_edge = 1'b0;
  cmd_t exp_q[$];
  cmd_t bus_q[$];
  int   wq[$];
  int   glog[$];
  cmd_t dq[N][$];
  int   acc_cnt[N];
  int   pend_tot[N];
  int   pend_used[N];
  int   refill = 0;
  int   force_waits = 0;
  int   mdl_ptr = 0;
  bit   mdl_busy = 0;

  always @(posedge pclk) begin
    cyc      <= cyc + 1;
    rst_edge <= !presetn;
  end

  // Slave behaviour, chosen so expected data/error follow from the address alone.
  function automatic logic [DW-1:0] slave_rd(logic [AW-1:0] a);
    return a[7:0] ^ 8'hA0;
  endfunction
  function automatic logic slave_err(logic [AW-1:0] a);
    return a[7:4] == 4'hE;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_master(cmd_t c, string tag);
    logic [31:0] e;
    e = {4'd0, !c.wr, c.wr, (c.wr ? '0 : c.addr), (c.wr ? c.addr : '0), (c.wr ? c.data : '0)};
    chk(tag, {4'd0, m_read, m_write, m_read_paddr, m_write_paddr, m_write_data}, e);
  endtask

  // Reference model and response monitor.
  always @(negedge pclk) begin : mon
    cmd_t c;
    int   win, w, idx;
    if (rst_edge) begin
      exp_q.delete(); bus_q.delete(); wq.delete();
      mdl_ptr  = 0;
      mdl_busy = 0;
    end
    if (!presetn && rst_edge) begin
      chk("reset_outputs", {req_ready, rsp_valid, m_transfer, busy, rsp_id, rsp_rdata, rsp_err,
                            m_read, m_write}, 32'd0);
      chk("reset_addr", {m_read_paddr, m_write_paddr, m_write_data}, 32'd0);
    end else if (presetn) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: got id %0d expected none (cycle %0d)", rsp_id, cyc);
        end else begin
          c = exp_q.pop_front();
          w = (wq.size() != 0) ? wq.pop_front() : -100;
          chk("rsp_id", rsp_id, c.id);
          chk("rsp_rdata", rsp_rdata, c.wr ? 8'd0 : slave_rd(c.addr));
          chk("rsp_err", rsp_err, slave_err(c.addr));
          chk("rsp_cycle", cyc, c.acc + 4 + w);
        end
      end else begin
        chk("rsp_zero", {rsp_id, rsp_rdata, rsp_err}, 32'd0);
      end
      if (!mdl_busy || rsp_valid)
        chk("m_idle_zero", {m_transfer, m_read, m_write, m_read_paddr, m_write_paddr, m_write_data}, 32'd0);
      if (!mdl_busy) begin
        win = -1;
        for (int k = 0; k < N; k++) begin
          idx = (mdl_ptr + k) % N;
          if (win < 0 && req_valid[idx]) win = idx;
        end
        chk("req_ready", req_ready, (win < 0) ? 0 : (1 << win));
        chk("busy_idle", busy, 0);
        if (win >= 0) begin
          c.id   = win;
          c.wr   = req_write[win];
          c.addr = req_addr[win*AW +: AW];
          c.data = req_wdata[win*DW +: DW];
          c.acc  = cyc;
          exp_q.push_back(c);
          bus_q.push_back(c);
          glog.push_back(win);
          acc_cnt[win]++;
          mdl_ptr  = (win + 1) % N;
          mdl_busy = 1;
        end
      end else begin
        chk("req_ready_busy", req_ready, 0);
        chk("busy_active", busy, 1);
      end
      if (rsp_valid) mdl_busy = 0;
    end
  end

  // APB master/slave stand-in: SETUP the cycle after m_transfer, then ENABLE with w wait states.
  initial begin : bus
    cmd_t c;
    int   w;
    bit   ab;
    forever begin
      @(negedge pclk);
      if (presetn && m_transfer) begin
        if (bus_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_transfer: got m_transfer=1 expected 0 (cycle %0d)", cyc);
        end else begin
          c = bus_q.pop_front();
          chk("issue_cycle", cyc, c.acc + 1);
          chk_master(c, "m_issue");
          w = (force_waits >= 0) ? force_waits : $urandom_range(0, 3);
          wq.push_back(w);
          ab = 0;
          @(posedge pclk); #1;
          penable = 1'b0; pready = 1'($urandom_range(0, 1));
          pslverr = 1'($urandom_range(0, 1)); prdata = 8'($urandom);
          @(negedge pclk);
          if (!presetn) ab = 1;
          else begin
            chk_master(c, "m_setup");
            chk("transfer_once", m_transfer, 0);
          end
          for (int k = 0; k <= w && !ab; k++) begin
            @(posedge pclk); #1;
            penable = 1'b1;
            pready  = (k == w);
            pslverr = (k == w) ? slave_err(c.addr) : 1'($urandom_range(0, 1));
            prdata  = (k == w) ? slave_rd(c.addr) : 8'($urandom);
            @(negedge pclk);
            if (!presetn) ab = 1;
            else chk_master(c, "m_enable");
          end
          @(posedge pclk); #1;
          penable = 1'b0; pready = 1'b0; pslverr = 1'b0; prdata = '0;
        end
      end
    end
  end

  // Requester driver: holds each command until its accept is seen, then loads the next.
  initial begin : drv
    cmd_t c;
    int   seen[N];
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < N; i++) seen[i] = 0;
    forever begin
      @(posedge pclk); #1;
      for (int i = 0; i < N; i++) begin
        if (acc_cnt[i] != seen[i]) begin
          seen[i] = acc_cnt[i];
          req_valid[i] = 1'b0;
          req_addr[i*AW +: AW]  = 9'($urandom);
          req_wdata[i*DW +: DW] = 8'($urandom);
        end
        if (!req_valid[i]) begin
          if (dq[i].size() != 0) begin
            c = dq[i].pop_front();
            req_write[i] = c.wr; req_addr[i*AW +: AW] = c.addr;
            req_wdata[i*DW +: DW] = c.data; req_valid[i] = 1'b1;
          end else if (pend_used[i] < pend_tot[i] &&
                       (refill == 1 || (refill == 2 && $urandom_range(0, 3) == 0))) begin
            req_write[i] = 1'($urandom_range(0, 1));
            req_addr[i*AW +: AW]  = 9'($urandom);
            req_wdata[i*DW +: DW] = 8'($urandom);
            req_valid[i] = 1'b1;
            pend_used[i]++;
          end
        end
      end
    end
  end

  task automatic push_cmd(int i, logic wr, logic [AW-1:0] a, logic [DW-1:0] d);
    cmd_t c;
    c.id = i; c.wr = wr; c.addr = a; c.data = d; c.acc = 0;
    dq[i].push_back(c);
  endtask

  function automatic bit work_left();
    bit b = (exp_q.size() != 0) || (req_valid != '0) || mdl_busy;
    for (int i = 0; i < N; i++)
      if (dq[i].size() != 0 || pend_used[i] < pend_tot[i]) b = 1;
    return b;
  endfunction

  task automatic wait_idle(string name, int bound);
    int n = 0;
    while (work_left() && n < bound) begin
      @(posedge pclk);
      n++;
    end
    repeat (3) @(posedge pclk);
    checks++;
    if (n >= bound) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending rsp after %0d cycles expected 0", name, exp_q.size(), n);
    end
  endtask

  initial begin : main
    int base;
    for (int i = 0; i < N; i++) begin
      acc_cnt[i] = 0; pend_tot[i] = 0; pend_used[i] = 0;
    end
    // Reset with every requester asking; afterwards they drain in order 0..3.
    for (int i = 0; i < N; i++) push_cmd(i, 1'b0, 9'(9'h040 + i), 8'h00);
    repeat (3) @(posedge pclk);
    #1 presetn = 1'b1;
    wait_idle("reset_drain", 200);

    // Single read, no wait states.
    force_waits = 0;
    push_cmd(1, 1'b0, 9'h105, 8'h00);
    wait_idle("single_read", 100);

    // Write with two wait states.
    force_waits = 2;
    push_cmd(2, 1'b1, 9'h022, 8'h3C);
    wait_idle("write_wait", 100);

    // Fairness after reset: all four continuously valid.
    force_waits = 0;
    @(posedge pclk); #1 presetn = 1'b0;
    base = glog.size();
    refill = 1;
    for (int i = 0; i < N; i++) pend_tot[i] += 3;
    repeat (2) @(posedge pclk);
    #1 presetn = 1'b1;
    wait_idle("fairness", 400);
    refill = 0;
    chk("fair_count", glog.size() - base, 12);
    for (int k = 0; k < 12 && base + k < glog.size(); k++)
      chk("fair_order", glog[base + k], k % N);

    // Slave error on one command only.
    force_waits = 1;
    push_cmd(0, 1'b0, 9'h0E3, 8'h00);
    wait_idle("err_cmd", 100);
    push_cmd(1, 1'b0, 9'h013, 8'h00);
    wait_idle("err_next", 100);

    // Reset while the bus is stalled in ENABLE; the dropped command must not respond.
    force_waits = 50;
    push_cmd(2, 1'b1, 9'h1F0, 8'h77);
    repeat (7) @(posedge pclk);
    #1 chk("stalled_busy", busy, 1);
    chk("stalled_penable", penable, 1);
    presetn = 1'b0;
    force_waits = 0;
    repeat (2) @(posedge pclk);
    #1 presetn = 1'b1;
    push_cmd(3, 1'b0, 9'h133, 8'h00);
    wait_idle("post_reset", 100);
    chk("post_reset_grant", glog[glog.size() - 1], 3);

    // Randomised traffic with random wait states.
    force_waits = -1;
    refill = 2;
    for (int i = 0; i < N; i++) pend_tot[i] += 15;
    wait_idle("random", 3000);
    chk("final_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #300000;
    errors++;
    $display("FAIL global_timeout: got no completion expected finish (cycle %0d)", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
